pipeline_hazard_controller: RTL and testbench

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

---
 rtl/pipeline_hazard_controller.sv | 126 ++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush controller for a 5-stage pipeline: branch flush, I-cache miss wait, load-use bubble.
// Optional statistics counters are enabled by defining PIPE_HAZARD_STATS_EN.
module pipeline_hazard_controller #(
  parameter int MISS_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hit,
  input  logic       PCSrc,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       exmem_flush,
  output logic [1:0] stall_state,
  output logic       miss_error
`ifdef PIPE_HAZARD_STATS_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MISS      = 2'd1,
    LU_BUBBLE = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT = 8'(MISS_TIMEOUT);

  state_t     state, state_next;
  logic [7:0] miss_cnt, miss_cnt_next;
  logic       load_use;

  assign load_use = ex_memread && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    pc_write      = 1'b1;
    ifid_write    = 1'b1;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    exmem_flush   = 1'b0;
    state_next    = state;
    miss_cnt_next = miss_cnt;

    if (PCSrc) begin
      ifid_flush    = 1'b1;
      idex_flush    = 1'b1;
      exmem_flush   = 1'b1;
      state_next    = RUN;
      miss_cnt_next = 8'd0;
    end else if (!hit) begin
      // Freeze fetch and feed a bubble downstream so older instructions drain.
      pc_write      = 1'b0;
      ifid_write    = 1'b0;
      ifid_flush    = 1'b1;
      state_next    = MISS;
      if (state == MISS)
        miss_cnt_next = (miss_cnt == 8'hFF) ? miss_cnt : miss_cnt + 8'd1;
      else
        miss_cnt_next = 8'd1;
    end else begin
      case (state)
        RUN: begin
          if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            state_next = LU_BUBBLE;
          end
        end
        LU_BUBBLE: state_next = RUN;
        MISS: begin
          state_next    = RUN;
          miss_cnt_next = 8'd0;
        end
        default: state_next = RUN;
      endcase
    end

    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      miss_cnt   <= 8'd0;
      miss_error <= 1'b0;
    end else begin
      state    <= state_next;
      miss_cnt <= miss_cnt_next;
      if (miss_cnt_next >= TIMEOUT && miss_cnt_next != 8'd0)
        miss_error <= 1'b1;
    end
  end

  assign stall_state = reset ? RUN : state;

`ifdef PIPE_HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= 32'd0;
      flush_count  <= 32'd0;
    end else begin
      if (!pc_write) stall_cycles <= stall_cycles + 32'd1;
      if (PCSrc)     flush_count  <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller; a second instance with MISS_TIMEOUT=3
// shares the stimulus to exercise the sticky timeout flag.
module tb_pipeline_hazard_controller;

  logic       clk = 1'b0;
  logic       reset, hit, PCSrc, id_uses_rt, ex_memread;
  logic [4:0] id_rs, id_rt, ex_rt;

  logic       pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, miss_error;
  logic [1:0] stall_state;
  logic       pc_write_t, ifid_write_t, ifid_flush_t, idex_flush_t, exmem_flush_t, miss_error_t;
  logic [1:0] stall_state_t;
`ifdef PIPE_HAZARD_STATS_EN
  logic [31:0] stall_cycles, flush_count, stall_cycles_t, flush_count_t;
`endif

  logic [6:0] outs;
  assign outs = {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, stall_state};

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller dut (
    .clk(clk), .reset(reset), .hit(hit), .PCSrc(PCSrc),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .stall_state(stall_state), .miss_error(miss_error)
`ifdef PIPE_HAZARD_STATS_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  pipeline_hazard_controller #(.MISS_TIMEOUT(3)) dut_t (
    .clk(clk), .reset(reset), .hit(hit), .PCSrc(PCSrc),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt),
    .pc_write(pc_write_t), .ifid_write(ifid_write_t), .ifid_flush(ifid_flush_t),
    .idex_flush(idex_flush_t), .exmem_flush(exmem_flush_t),
    .stall_state(stall_state_t), .miss_error(miss_error_t)
`ifdef PIPE_HAZARD_STATS_EN
    , .stall_cycles(stall_cycles_t), .flush_count(flush_count_t)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic h, input logic br, input logic mr, input logic [4:0] ert,
                        input logic [4:0] rs, input logic [4:0] rt, input logic urt);
    hit = h; PCSrc = br; ex_memread = mr; ex_rt = ert;
    id_rs = rs; id_rt = rt; id_uses_rt = urt;
  endtask

  task automatic idle();
    set_in(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  // Check the combinational outputs for this cycle, then advance past the next edge.
  // Output order: pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, stall_state[1:0].
  task automatic cyc(input string tag, input logic [6:0] exp);
    #2;
    check(tag, 32'(outs), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("reset_err", 32'(miss_error), 32'd0);
    cyc("reset_outs", 7'b00_111_00);
    reset = 1'b0;

    cyc("run_idle", 7'b11_000_00);

    // Load-use on rs: one stall, one bubble, back to RUN.
    set_in(1'b1, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
    cyc("lu_rs_stall", 7'b00_010_00);
    cyc("lu_rs_bubble", 7'b11_000_10);
    idle();
    cyc("lu_rs_run", 7'b11_000_00);

    // Load-use on rt.
    set_in(1'b1, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1);
    cyc("lu_rt_stall", 7'b00_010_00);
    idle();
    cyc("lu_rt_bubble", 7'b11_000_10);

    // No hazard: $zero destination, and rt not read.
    set_in(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
    cyc("no_lu_r0", 7'b11_000_00);
    set_in(1'b1, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0);
    cyc("no_lu_rt_unused", 7'b11_000_00);

    // Four miss cycles then hit.
    set_in(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    cyc("miss1", 7'b00_100_00);
    cyc("miss2", 7'b00_100_01);
    cyc("miss3", 7'b00_100_01);
    cyc("miss4", 7'b00_100_01);
    hit = 1'b1;
    cyc("miss_exit", 7'b11_000_01);
    cyc("miss_after_run", 7'b11_000_00);
    check("miss4_no_err", 32'(miss_error), 32'd0);
    check("miss4_err_t3", 32'(miss_error_t), 32'd1);

    // Timeout with MISS_TIMEOUT=3.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("tmo_cleared", 32'(miss_error_t), 32'd0);
    hit = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("tmo_edge%0d", k), 32'(miss_error_t), (k >= 3) ? 32'd1 : 32'd0);
    end
    hit = 1'b1;
    @(posedge clk);
    #1;
    check("tmo_held", 32'(miss_error_t), 32'd1);
    check("tmo_held_state", 32'(stall_state_t), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("tmo_reset", 32'(miss_error_t), 32'd0);
    reset = 1'b0;

    // Branch during MISS with a pending load-use.
    set_in(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    cyc("br_pre_miss", 7'b00_100_00);
    set_in(1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
    cyc("br_in_miss", 7'b11_111_01);
    idle();
    cyc("br_after", 7'b11_000_00);

    // Miss coincident with load-use: miss wins, hazard re-evaluated afterwards.
    set_in(1'b0, 1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0);
    cyc("lu_miss_coinc", 7'b00_100_00);
    hit = 1'b1;
    cyc("lu_miss_exit", 7'b11_000_01);
    cyc("lu_after_miss", 7'b00_010_00);
    hit = 1'b0;
    cyc("miss_from_bubble", 7'b00_100_10);

    // Reset mid-MISS abandons it.
    reset = 1'b1;
    cyc("rst_mid_miss", 7'b00_111_00);
    reset = 1'b0;
    idle();
    cyc("rst_then_run", 7'b11_000_00);

`ifdef PIPE_HAZARD_STATS_EN
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("stats_rst_stall", stall_cycles, 32'd0);
    check("stats_rst_flush", flush_count, 32'd0);
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0);
      cyc("stats_lu", 7'b00_010_00);
      idle();
      cyc("stats_bubble", 7'b11_000_10);
    end
    hit = 1'b0;
    cyc("stats_m1", 7'b00_100_00);
    cyc("stats_m2", 7'b00_100_01);
    cyc("stats_m3", 7'b00_100_01);
    hit = 1'b1;
    cyc("stats_mexit", 7'b11_000_01);
    PCSrc = 1'b1;
    cyc("stats_br", 7'b11_111_00);
    PCSrc = 1'b0;
    #2;
    check("stats_stall_cycles", stall_cycles, 32'd5);
    check("stats_flush_count", flush_count, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
